// File: rtl/digit_serial_addsub_pkg.sv
// rtl/digit_serial_addsub_pkg.sv - shared state encoding and mode constants for digit_serial_addsub
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } addsub_state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/digit_serial_addsub_digit_adder.sv
// rtl/digit_serial_addsub_digit_adder.sv - combinational DIGIT-bit ripple adder
// c_msb exposes the carry into the top bit so the caller can derive signed overflow.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] w_c;

   always_comb begin
      w_c    = '0;
      sum    = '0;
      w_c[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
      end
      cout  = w_c[DIGIT];
      c_msb = w_c[DIGIT-1];
   end

endmodule

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - digit-serial two's-complement adder/subtractor with valid/ready handshakes
// Optional build macro ADDSUB_SATURATE_EN clamps overflowed results to the signed limit.
module digit_serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NUM_DIGITS = WIDTH / DIGIT;
   localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   generate
      if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
      end
   endgenerate

   addsub_state_t    r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_k;
   logic [WIDTH-1:0] r_result;
   logic             r_carry_out;
   logic             r_overflow;
   logic             r_zero;
   logic             r_negative;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [DIGIT-1:0] w_a_dig;
   logic [DIGIT-1:0] w_b_dig;
   logic [DIGIT-1:0] w_sum;
   logic             w_cout;
   logic             w_c_msb;
   logic             w_ovf;
   logic             w_last;
   logic [WIDTH-1:0] w_merged;
   logic [WIDTH-1:0] w_final;

   digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
      .a     (w_a_dig),
      .b     (w_b_dig),
      .cin   (r_carry),
      .sum   (w_sum),
      .cout  (w_cout),
      .c_msb (w_c_msb)
   );

   // Select digit k of each operand and splice the new sum digit into the running result.
   always_comb begin
      w_a_dig  = '0;
      w_b_dig  = '0;
      w_merged = r_result;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_k == CW'(i)) begin
            w_a_dig                       = r_a[i*DIGIT +: DIGIT];
            w_b_dig                       = r_b[i*DIGIT +: DIGIT];
            w_merged[i*DIGIT +: DIGIT]    = w_sum;
         end
      end
      w_ovf  = w_c_msb ^ w_cout;
      w_last = (r_k == CW'(NUM_DIGITS - 1));
`ifdef ADDSUB_SATURATE_EN
      if (w_ovf)
         w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         w_final = w_merged;
`else
      w_final = w_merged;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_k         <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
         r_negative  <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= a;
                  r_b        <= (mode == MODE_SUB) ? ~b : b;
                  r_carry    <= mode;
                  r_k        <= '0;
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
               end
            end
            RUN: begin
               r_carry <= w_cout;
               r_k     <= r_k + CW'(1);
               if (w_last) begin
                  r_result    <= w_final;
                  r_carry_out <= w_cout;
                  r_overflow  <= w_ovf;
                  r_zero      <= (w_final == '0);
                  r_negative  <= w_final[WIDTH-1];
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_result <= w_merged;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;
   assign zero      = r_zero;
   assign negative  = r_negative;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - self-checking bench for digit_serial_addsub (WIDTH=16, DIGIT=4)
module tb_digit_serial_addsub;

   localparam int W       = 16;
   localparam int LATENCY = 5;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         zero;
   logic         negative;

   int n_tests = 0;
   int n_fail  = 0;

   digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the whole word, signed overflow from operand/result signs.
   task automatic model(input logic m, input logic [W-1:0] ma, input logic [W-1:0] mb,
                        output logic [W-1:0] er, output logic ec, output logic eo,
                        output logic ez, output logic en);
      int unsigned full;
      int          sa, sb, st;
      sa = $signed(ma);
      sb = $signed(mb);
      if (m) begin
         full = int'(ma) + (32'h10000 - int'(mb));
         st   = sa - sb;
      end else begin
         full = int'(ma) + int'(mb);
         st   = sa + sb;
      end
      er = full[W-1:0];
      ec = full[W];
      eo = (st > 32767) || (st < -32768);
`ifdef ADDSUB_SATURATE_EN
      if (eo) er = (st > 0) ? 16'h7FFF : 16'h8000;
`endif
      ez = (er == '0);
      en = er[W-1];
   endtask

   // Drives one operation and waits for its result; lat = -1 if any bounded wait expired.
   task automatic do_op(input logic m, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        output logic [W-1:0] r, output logic [3:0] f, output int lat);
      int waited;
      lat    = -1;
      r      = '0;
      f      = '0;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      mode     = m;
      a        = oa;
      b        = ob;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (out_valid) begin
            lat = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (lat < 0) return;
      r = result;
      f = {carry_out, overflow, zero, negative};
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mode      = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_tests++;
      if ({in_ready, out_valid, result, carry_out, overflow, zero, negative} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
         n_fail++;
         $display("FAIL reset_state got rdy=%b vld=%b res=%h flags=%b%b%b%b need rdy=1 vld=0 res=0000 flags=0000",
                  in_ready, out_valid, result, carry_out, overflow, zero, negative);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [6] = '{16'h1234, 16'h0005, 16'h1234, 16'h7FFF, 16'h8000, 16'h0000};
      logic [W-1:0] vb [6] = '{16'h0FCC, 16'h0007, 16'h1234, 16'h0001, 16'h0001, 16'h0000};
      logic         vm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] r, er;
      logic [3:0]   f;
      logic         ec, eo, ez, en;
      int           lat;
      for (int i = 0; i < 6; i++) begin
         model(vm[i], va[i], vb[i], er, ec, eo, ez, en);
         do_op(vm[i], va[i], vb[i], r, f, lat);
         n_tests++;
         if ({r, f} !== {er, ec, eo, ez, en} || lat != LATENCY) begin
            n_fail++;
            $display("FAIL directed_%0d got res=%h flags(c,o,z,n)=%b lat=%0d need res=%h flags=%b%b%b%b lat=%0d",
                     i, r, f, lat, er, ec, eo, ez, en, LATENCY);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb, r, er;
      logic         rm, ec, eo, ez, en;
      logic [3:0]   f;
      int           lat;
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rm = 1'($urandom);
         if (i % 8 == 0) rb = ra;
         if (i % 8 == 1) ra = 16'h8000;
         model(rm, ra, rb, er, ec, eo, ez, en);
         do_op(rm, ra, rb, r, f, lat);
         n_tests++;
         if ({r, f} !== {er, ec, eo, ez, en} || lat != LATENCY) begin
            n_fail++;
            $display("FAIL random_%0d m=%b a=%h b=%h got res=%h flags=%b lat=%0d need res=%h flags=%b%b%b%b lat=%0d",
                     i, rm, ra, rb, r, f, lat, er, ec, eo, ez, en, LATENCY);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held_r, r, er;
      logic [3:0]   held_f;
      logic         ec, eo, ez, en;
      int           lat;
      bit           ok;
      @(negedge clk);
      in_valid = 1'b1;
      mode     = 1'b0;
      a        = 16'h7FFF;
      b        = 16'h0001;
      @(posedge clk);
      #1;
      a  = 16'h4000;
      b  = 16'h0123;
      mode = 1'b1;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         if (out_valid) begin
            lat = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      n_tests++;
      if (lat != LATENCY || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_first_done got lat=%0d in_ready=%b need lat=%0d in_ready=0", lat, in_ready, LATENCY);
      end
      held_r = result;
      held_f = {carry_out, overflow, zero, negative};
      model(1'b0, 16'h7FFF, 16'h0001, er, ec, eo, ez, en);
      n_tests++;
      if ({held_r, held_f} !== {er, ec, eo, ez, en}) begin
         n_fail++;
         $display("FAIL bp_first_result got res=%h flags=%b need res=%h flags=%b%b%b%b",
                  held_r, held_f, er, ec, eo, ez, en);
      end
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         a = W'($urandom);
         if (!out_valid || in_ready || result !== held_r ||
             {carry_out, overflow, zero, negative} !== held_f) ok = 1'b0;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_hold got vld=%b rdy=%b res=%h need vld=1 rdy=0 res=%h held over 10 cycles",
                  out_valid, in_ready, result, held_r);
      end
      a = 16'h4000;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release got vld=%b rdy=%b need vld=0 rdy=1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         if (out_valid) begin
            lat = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      r = result;
      model(1'b1, 16'h4000, 16'h0123, er, ec, eo, ez, en);
      n_tests++;
      if ({r, carry_out, overflow, zero, negative} !== {er, ec, eo, ez, en} || lat != LATENCY) begin
         n_fail++;
         $display("FAIL bp_second_op got res=%h flags=%b%b%b%b lat=%0d need res=%h flags=%b%b%b%b lat=%0d",
                  r, carry_out, overflow, zero, negative, lat, er, ec, eo, ez, en, LATENCY);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] r;
      logic [3:0]   f;
      int           lat;
      @(negedge clk);
      in_valid = 1'b1;
      mode     = 1'b0;
      a        = 16'hFFFF;
      b        = 16'hFFFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_tests++;
      if ({in_ready, out_valid, result, carry_out, overflow, zero, negative} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_run got rdy=%b vld=%b res=%h flags=%b%b%b%b need rdy=1 vld=0 res=0000 flags=0000",
                  in_ready, out_valid, result, carry_out, overflow, zero, negative);
      end
      do_op(1'b0, 16'h0001, 16'h0001, r, f, lat);
      n_tests++;
      if ({r, f} !== {16'h0002, 4'b0000} || lat != LATENCY) begin
         n_fail++;
         $display("FAIL after_reset_add got res=%h flags=%b lat=%0d need res=0002 flags=0000 lat=%0d",
                  r, f, lat, LATENCY);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor, successor to the fixed 4-bit add/sub block. Processes WIDTH-bit two's-complement operands DIGIT bits per clock, with a valid/ready handshake on both sides. Outputs status flags (carry, overflow, zero, negative). Intended as the shared arithmetic unit for datapaths where area matters more than throughput.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock; DIGIT == WIDTH gives a single RUN cycle.
NUM_DIGITS, WIDTH/DIGIT, derived localparam; not overridable.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_n  input  1  reset: synchronous, active-low.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept an operation.
mode  input  1  0 = add (a+b), 1 = subtract (a-b).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  sum or difference.
carry_out  output  1  final carry; for subtract, 1 = no borrow.
overflow  output  1  signed overflow.
zero  output  1  result == 0.
negative  output  1  result MSB.

Behaviour:
- Reset (rst_n low at a clock edge, in any state): state goes to IDLE. out_valid=0, result=0, all flags=0, digit counter=0. Any in-flight operation is discarded. in_ready=1 in the first cycle after reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on in_valid && in_ready. Latch a, b and mode. Initialise carry register to mode. Latch B as ~b when mode=1. Clear the counter.
  - RUN: each cycle, add digit k of A, digit k of B(inv) and the carry register. Store the DIGIT-bit sum into result bits [k*DIGIT +: DIGIT]. Register the carry out and increment k.
  - RUN -> DONE on the cycle that processes k == NUM_DIGITS-1.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- No overlap between operations: the cycle after the output handshake is IDLE.
- Latency: handshake in cycle 0 gives out_valid in cycle NUM_DIGITS+1 (cycle 5 at the defaults).
- in_valid while not IDLE is ignored, and operands are not sampled.
- In DONE, result and flags are held stable until the output handshake, regardless of inputs.
- result is updated only in RUN, so partial values are visible but are qualified by out_valid=0.
- Flags are registered on entry to DONE:
  - carry_out = carry out of the MSB digit.
  - overflow = carry into the MSB XOR carry out of the MSB (taken from the last digit).
  - zero = (final result == 0).
  - negative = final result[WIDTH-1].
- Arithmetic is modulo 2^WIDTH.
- Elaboration error if WIDTH % DIGIT != 0, DIGIT < 1 or WIDTH < 2.

Optional Feature:
ADDSUB_SATURATE_EN:
- Defined: on entry to DONE with overflow=1, result is clamped to the signed limit. The limit is 2^(WIDTH-1)-1 when the true result is positive (operand-A sign 0) and -2^(WIDTH-1) otherwise.
  - overflow still reports 1.
  - zero and negative are computed from the clamped result.
  - carry_out is unchanged.
- Undefined: result wraps; no clamp logic is generated.
- Latency is identical in both builds.

Decomposition:
- Package addsub_pkg holds:
  - state enum typedef addsub_state_t (IDLE, RUN, DONE);
  - constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
- One sub-module, digit_adder: a DIGIT-bit ripple adder with ports a, b, cin, sum, cout, and c_msb (carry into its top bit), all combinational.
- The FSM, counter, operand registers and flag logic stay in the top module.

Test Plan (WIDTH=16, DIGIT=4):
1. add 0x1234+0x0FCC, handshake in cycle 0 -> out_valid in cycle 5 with result=0x2200, carry_out=0, overflow=0, zero=0, negative=0.
2. sub 0x0005-0x0007 -> result=0xFFFE, carry_out=0, negative=1, overflow=0. Then sub 0x1234-0x1234 -> result=0x0000, zero=1, carry_out=1.
3. add 0x7FFF+0x0001 -> result=0x8000, overflow=1, negative=1. With ADDSUB_SATURATE_EN: result=0x7FFF, negative=0, overflow=1.
4. sub 0x8000-0x0001 -> result=0x7FFF, overflow=1, carry_out=1. With ADDSUB_SATURATE_EN: result=0x8000, negative=1.
5. Backpressure: out_ready=0 for 10 cycles in DONE, with in_valid=1 carrying new operands -> result and flags stable, in_ready=0, nothing accepted. Raise out_ready -> IDLE next cycle, then the new operation is accepted and completes correctly.
6. Drive rst_n=0 for one cycle during RUN (k=2) -> next cycle: IDLE, out_valid=0, in_ready=1, result=0, flags=0. A following add 0x0001+0x0001 returns 0x0002.
